// File: rtl/memory_access_unit_pkg.sv
// Shared CPU definitions for the memory-stage data-memory master.
//   mem_access_state_t : FSM state encoding (IDLE, ACCESS, DONE)
//   BYTEENABLE_WORD    : lane mask for a full 32-bit word access
package memory_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_access_state_t;

    localparam logic [3:0] BYTEENABLE_WORD = 4'b1111;

endpackage

// File: rtl/memory_access_unit.sv
// Memory-stage data-memory master. Converts load/store requests into
// Avalon-MM read/write transfers, stalls the pipeline while a transfer is
// outstanding and holds the last loaded word for the MEM/WB register.
//
// Ports:
//   clk, reset                 pipeline clock, async active-high reset
//   memory_read_memory         load request from the memory stage
//   memory_write_memory        store request from the memory stage
//   address_memory             byte address (low 2 bits dropped on the bus)
//   write_data_memory          store data
//   byteenable_memory          lane enables
//   avm_*                      Avalon-MM master signals
//   read_data_memory           captured load word
//   stall_memory               freezes stages up to and including memory
//   state_debug                current FSM state, for observation only
//
// Handshake: a request (read or write) is held by the pipeline while
// stall_memory is 1. On the bus, avm_read/avm_write and all qualifiers stay
// constant while avm_waitrequest is 1; the transfer completes at the first
// clock edge where avm_waitrequest is 0, and avm_readdata is taken then.
module memory_access_unit
    import memory_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_read_memory,
    input  logic              memory_write_memory,
    input  logic [31:0]       address_memory,
    input  logic [31:0]       write_data_memory,
    input  logic [3:0]        byteenable_memory,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [31:0]       read_data_memory,
    output logic              stall_memory,
    output mem_access_state_t state_debug
);

    mem_access_state_t state;
    logic              request;

    // Byte offset is carried by byteenable only, so these bits go nowhere.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_memory[1:0];

    assign request     = memory_read_memory | memory_write_memory;
    assign state_debug = state;

    // DONE deliberately reports no stall: it is the one cycle where the
    // pipeline advances past the completed instruction.
    assign stall_memory = (state == ACCESS) | ((state == IDLE) & request);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            avm_address      <= 32'd0;
            avm_read         <= 1'b0;
            avm_write        <= 1'b0;
            avm_writedata    <= 32'd0;
            avm_byteenable   <= 4'd0;
            read_data_memory <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        avm_address    <= {address_memory[31:2], 2'b00};
                        avm_writedata  <= write_data_memory;
                        avm_byteenable <= byteenable_memory;
                        // A simultaneous read and write resolves to the write.
                        avm_write      <= memory_write_memory;
                        avm_read       <= memory_read_memory & ~memory_write_memory;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!avm_waitrequest) begin
                        if (avm_read) begin
                            read_data_memory <= avm_readdata;
                        end
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // The request inputs still show the finished instruction
                    // here, so they must not be looked at.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: a table of directed
// transactions, randomized transactions against a transaction-level model,
// and hand-written sequences for idle and reset-during-access behaviour.
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    logic              clk;
    logic              reset;
    logic              rd;
    logic              wr;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              waitreq;
    logic [31:0]       rdata_bus;
    logic [31:0]       read_data_memory;
    logic              stall_memory;
    mem_access_state_t state_debug;

    int passed = 0;
    int total  = 0;
    logic [31:0] model_rdm;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          nwait;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic        e_rd;
        logic        e_wr;
        int          e_stall;
        int          e_strobe;
        logic [31:0] e_rdm;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    memory_access_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .memory_read_memory  (rd),
        .memory_write_memory (wr),
        .address_memory      (addr),
        .write_data_memory   (wdata),
        .byteenable_memory   (be),
        .avm_address         (avm_address),
        .avm_read            (avm_read),
        .avm_write           (avm_write),
        .avm_writedata       (avm_writedata),
        .avm_byteenable      (avm_byteenable),
        .avm_waitrequest     (waitreq),
        .avm_readdata        (rdata_bus),
        .read_data_memory    (read_data_memory),
        .stall_memory        (stall_memory),
        .state_debug         (state_debug)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {avm_address, avm_writedata, avm_byteenable, avm_read, avm_write, stall_memory},
              72'd0);
        check({name, "_rdm"}, read_data_memory, 72'd0);
        check({name, "_state"}, state_debug, IDLE);
    endtask

    // Drives one request and plays the slave: waitrequest is held high for
    // t_nwait strobe cycles, readdata is garbage until the completing cycle.
    task automatic run_txn(input logic t_rd, input logic t_wr, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, input logic [3:0] t_be, input int t_nwait,
                           input logic [31:0] t_rdata, input logic [31:0] e_addr,
                           input logic e_rd, input logic e_wr, input int e_stall,
                           input int e_strobe, input logic [31:0] e_rdm);
        int  stall_cnt  = 0;
        int  strobe_cnt = 0;
        int  waits_left = t_nwait;
        bit  done       = 0;
        bit  strobe_now;
        @(negedge clk);
        rd = t_rd; wr = t_wr; addr = t_addr; wdata = t_wdata; be = t_be;
        waitreq = 1'b1; rdata_bus = $urandom;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (!stall_memory) begin
                done = 1;
            end else begin
                stall_cnt++;
                strobe_now = avm_read | avm_write;
                if (strobe_now) begin
                    strobe_cnt++;
                    check("bus_hold", {avm_address, avm_writedata, avm_byteenable, avm_read, avm_write},
                          {e_addr, t_wdata, t_be, e_rd, e_wr});
                    waitreq   = (waits_left > 0);
                    rdata_bus = waitreq ? $urandom : t_rdata;
                end else begin
                    waitreq   = 1'b1;
                    rdata_bus = $urandom;
                end
                @(posedge clk);
                if (strobe_now && waits_left > 0) waits_left--;
            end
        end
        check("txn_completed", done, 1);
        check("stall_cycles", stall_cnt, e_stall);
        check("strobe_cycles", strobe_cnt, e_strobe);
        check("done_strobes", {avm_read, avm_write}, 0);
        check("done_state", state_debug, DONE);
        check("read_data", read_data_memory, e_rdm);
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; waitreq = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("idle_quiet", {stall_memory, avm_read, avm_write}, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        // Directed vectors with hand-derived expectations.
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1006, 32'h0, BYTEENABLE_WORD, 0, 32'hDEAD_BEEF,
                    32'h0000_1004, 1'b1, 1'b0, 2, 1, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2001, 32'h1234_5678, 4'b0011, 3, 32'h5555_AAAA,
                    32'h0000_2000, 1'b0, 1'b1, 5, 4, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3003, 32'hAAAA_5555, BYTEENABLE_WORD, 1, 32'h1111_1111,
                    32'h0000_3000, 1'b0, 1'b1, 3, 2, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, BYTEENABLE_WORD, 0, 32'hCAFE_0001,
                    32'h0000_0100, 1'b1, 1'b0, 2, 1, 32'hCAFE_0001};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, BYTEENABLE_WORD, 2, 32'hCAFE_0002,
                    32'h0000_0104, 1'b1, 1'b0, 4, 3, 32'hCAFE_0002};

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
        waitreq = 1'b0; rdata_bus = '0;
        #2;
        check_all_zero("reset_values");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        idle_cycles(10);

        // Entries 3 and 4 run back-to-back: one DONE cycle separates them.
        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    vecs[i].nwait, vecs[i].rdata, vecs[i].e_addr, vecs[i].e_rd, vecs[i].e_wr,
                    vecs[i].e_stall, vecs[i].e_strobe, vecs[i].e_rdm);
        end
        model_rdm = 32'hCAFE_0002;

        // Randomized transactions against a transaction-level model.
        for (int i = 0; i < 30; i++) begin
            logic        r_rd, r_wr;
            logic [31:0] r_addr, r_wdata, r_rdata;
            logic [3:0]  r_be;
            int          r_nwait;
            r_rd    = 1'($urandom_range(0, 1));
            r_wr    = 1'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_be    = 4'($urandom_range(0, 15));
            r_nwait = $urandom_range(0, 4);
            if (!r_rd && !r_wr) begin
                idle_cycles($urandom_range(1, 3));
            end else begin
                if (!r_wr) model_rdm = r_rdata;
                run_txn(r_rd, r_wr, r_addr, r_wdata, r_be, r_nwait, r_rdata,
                        r_addr & 32'hFFFF_FFFC, r_rd & !r_wr, r_wr, 2 + r_nwait,
                        1 + r_nwait, model_rdm);
            end
        end

        // Reset in the middle of a stalled read.
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 32'h0000_0500; waitreq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_access", {state_debug, avm_read}, {ACCESS, 1'b1});
        reset = 1'b1; rd = 1'b0;
        #1;
        check_all_zero("mid_access_reset");
        model_rdm = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post_reset_idle", {state_debug, avm_read, avm_write, stall_memory}, {IDLE, 3'b000});

        // Unit is usable again and has not retried the abandoned read.
        run_txn(1'b1, 1'b0, 32'h0000_0A0B, 32'h0, BYTEENABLE_WORD, 1, 32'h0BAD_F00D,
                32'h0000_0A08, 1'b1, 1'b0, 3, 2, 32'h0BAD_F00D);
        idle_cycles(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
